output_port_arbiter: RTL

Wormhole output-port arbiter for one router output. It shares the output link among `NUM_INPUTS` input FIFOs using round-robin arbitration at packet granularity: a packet that wins the port keeps it until its tail flit has passed. The block pops flits from the granted FIFO, drives a registered output flit stage, and enforces downstream credit-based flow control. One instance sits on each router output port, between the input FIFOs and the link.

---
 rtl/output_port_arbiter_if.sv | 25 ++
 rtl/output_port_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/output_port_arbiter_if.sv
// Handshake and data bundle between the input FIFOs, the output-port arbiter and the link.
// The arbiter connects through the slave modport and the FIFO/link side through the master modport.
interface output_port_arbiter_if #(
    parameter int NUM_INPUTS = 5,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_INPUTS-1:0]            req;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] flit_in;
    logic [NUM_INPUTS-1:0]            pop;
    logic [NUM_INPUTS-1:0]            grant;
    logic                             out_valid;
    logic [DATA_WIDTH-1:0]            out_flit;
    logic                             credit_return;
    logic                             credit_err;

    modport master (
        output req, flit_in, credit_return,
        input  pop, grant, out_valid, out_flit, credit_err
    );

    modport slave (
        input  req, flit_in, credit_return,
        output pop, grant, out_valid, out_flit, credit_err
    );
endinterface

// File: rtl/output_port_arbiter.sv
// Wormhole round-robin output-port arbiter: a head wins in 1 cycle, then the flit appears 1 cycle after its pop.
// Backpressure: pops stall while downstream credits are 0, and a bubble on the owner's req holds the lock.
module output_port_arbiter #(
    parameter int NUM_INPUTS  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int CREDIT_BITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    output_port_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CREDIT_BITS:0] CRED_MAX = {1'b1, {CREDIT_BITS{1'b0}}};
    localparam logic [CREDIT_BITS:0] CRED_ONE = {{CREDIT_BITS{1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic [NUM_INPUTS-1:0] ONE_HOT0 = {{(NUM_INPUTS-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        rr;
    logic [IDX_W-1:0]        owner;
    logic [CREDIT_BITS:0]    credits;
    logic [NUM_INPUTS-1:0]   grant_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_flit_q;
    logic                    credit_err_q;

    logic [DATA_WIDTH-1:0]   flits [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]   eligible;
    logic [DATA_WIDTH-1:0]   owner_flit;
    logic                    pop_fire;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;

    // Only head or single-flit types (type bit 0) may open a new packet.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_slice
        assign flits[gi]    = bus.flit_in[gi*DATA_WIDTH +: DATA_WIDTH];
        assign eligible[gi] = bus.req[gi] & bus.flit_in[gi*DATA_WIDTH + DATA_WIDTH - 2];
    end

    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = (int'(rr) + k) % NUM_INPUTS;
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign owner_flit = flits[owner];
    // Pop never looks at flit contents, only ownership, the owner's req and credits.
    assign pop_fire   = (state == LOCKED) && bus.req[owner] && (credits != '0);

    assign bus.pop        = pop_fire ? (ONE_HOT0 << owner) : '0;
    assign bus.grant      = grant_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_flit   = out_flit_q;
    assign bus.credit_err = credit_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr           <= '0;
            owner        <= '0;
            grant_q      <= '0;
            credits      <= CRED_MAX;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            credit_err_q <= 1'b0;
        end else begin
            out_valid_q <= pop_fire;
            if (pop_fire) begin
                out_flit_q <= owner_flit;
            end

            // Simultaneous pop and return cancel; a return at full saturates and flags.
            case ({pop_fire, bus.credit_return})
                2'b10: credits <= credits - CRED_ONE;
                2'b01: begin
                    if (credits == CRED_MAX) begin
                        credit_err_q <= 1'b1;
                    end else begin
                        credits <= credits + CRED_ONE;
                    end
                end
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (win_found) begin
                        state   <= LOCKED;
                        owner   <= win_idx;
                        grant_q <= ONE_HOT0 << win_idx;
                    end
                end
                LOCKED: begin
                    if (pop_fire && owner_flit[DATA_WIDTH-1]) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        rr      <= (owner == LAST_IDX) ? '0 : owner + IDX_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
